// File: rtl/div_bus_sequencer.sv
// Byte-bus front end for a 16-bit divider: gathers four operand bytes, starts the
// divider, waits for its result under a timeout, then streams four result bytes.
module div_bus_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sw_clr,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] div_A,
    output logic [15:0] div_B,
    output logic        div_start,
    input  logic        div_ready,
    input  logic        div_error,
    input  logic [15:0] div_Q,
    input  logic [15:0] div_R,
    output logic        busy,
    output logic        err_div,
    output logic        err_tmo
);

    localparam int unsigned WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_SEND
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [15:0]   a_q, a_d, b_q, b_d;
    logic [15:0]   q_q, q_d, r_q, r_d;
    logic          err_div_q, err_div_d;
    logic          err_tmo_q, err_tmo_d;

    logic in_fire, out_fire, capture, timeout;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // The first WAIT cycle (wait_q == 0) never captures, so a stale ready level is ignored.
    assign capture  = (state_q == S_WAIT) && (wait_q != '0) && div_ready;
    assign timeout  = (state_q == S_WAIT) && !capture && (wait_q == WAIT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wait_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            q_q       <= '0;
            r_q       <= '0;
            err_div_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            a_q       <= a_d;
            b_q       <= b_d;
            q_q       <= q_d;
            r_q       <= r_d;
            err_div_q <= err_div_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sw_clr) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (in_fire) state_d = S_LOAD;
                S_LOAD:  if (in_fire && cnt_q == 2'd3) state_d = S_START;
                S_START: state_d = S_WAIT;
                S_WAIT:  if (capture || timeout) state_d = S_SEND;
                S_SEND:  if (out_fire && cnt_q == 2'd3) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        a_d       = a_q;
        b_d       = b_q;
        q_d       = q_q;
        r_d       = r_q;
        err_div_d = err_div_q;
        err_tmo_d = err_tmo_q;
        if (sw_clr) begin
            cnt_d  = '0;
            wait_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_fire) begin
                        a_d[7:0]  = in_data;
                        cnt_d     = 2'd1;
                        err_div_d = 1'b0;
                        err_tmo_d = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_fire) begin
                        unique case (cnt_q)
                            2'd0: a_d[7:0]  = in_data;
                            2'd1: a_d[15:8] = in_data;
                            2'd2: b_d[7:0]  = in_data;
                            2'd3: b_d[15:8] = in_data;
                            default: ;
                        endcase
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                S_START: begin
                    wait_d = '0;
                end
                S_WAIT: begin
                    if (capture) begin
                        q_d       = div_error ? 16'hFFFF : div_Q;
                        r_d       = div_error ? 16'hFFFF : div_R;
                        err_div_d = div_error;
                        cnt_d     = '0;
                        wait_d    = '0;
                    end else if (timeout) begin
                        q_d       = 16'hFFFF;
                        r_d       = 16'hFFFF;
                        err_tmo_d = 1'b1;
                        cnt_d     = '0;
                        wait_d    = '0;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
                S_SEND: begin
                    if (out_fire) cnt_d = cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
        out_valid = (state_q == S_SEND);
        div_start = (state_q == S_START);
        busy      = (state_q != S_IDLE);
        out_data  = 8'h00;
        if (state_q == S_SEND) begin
            unique case (cnt_q)
                2'd0: out_data = q_q[7:0];
                2'd1: out_data = q_q[15:8];
                2'd2: out_data = r_q[7:0];
                2'd3: out_data = r_q[15:8];
                default: out_data = 8'h00;
            endcase
        end
    end

    assign div_A   = a_q;
    assign div_B   = b_q;
    assign err_div = err_div_q;
    assign err_tmo = err_tmo_q;

endmodule
